// File: rtl/dx_pkg.sv
// Shared definitions for the D/X stage: opcodes, field slices, writer/source
// classification and the select/match bundles.
package dx_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;

  localparam logic [31:0] NOP = 32'h0;

  typedef struct packed {
    logic rs;
    logic rt;
    logic rd;
  } src_match_t;

  typedef struct packed {
    logic mx_rs;
    logic wx_rs;
    logic mx_rt;
    logic wx_rt;
    logic mx_rd;
    logic wx_rd;
  } byp_sel_t;

  function automatic logic [4:0] f_op(input logic [31:0] i);
    return i[31:27];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] i);
    return i[26:22];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] i);
    return i[21:17];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] i);
    return i[16:12];
  endfunction

  // A write to r0 is discarded, so it never creates a dependency.
  function automatic logic writes_rd(input logic [31:0] i);
    return ((f_op(i) == OP_RTYPE) || (f_op(i) == OP_ADDI) || (f_op(i) == OP_LW))
           && (f_rd(i) != 5'd0);
  endfunction

  function automatic logic uses_rd(input logic [31:0] i);
    return (f_op(i) == OP_SW) || (f_op(i) == OP_BNE) || (f_op(i) == OP_BLT);
  endfunction

  function automatic logic uses_rt(input logic [31:0] i);
    return f_op(i) == OP_RTYPE;
  endfunction

  function automatic logic uses_rs(input logic [31:0] i);
    return uses_rt(i) || uses_rd(i) || (f_op(i) == OP_ADDI) || (f_op(i) == OP_LW);
  endfunction

endpackage

// File: rtl/dx_stage_if.sv
// Bus between fetch/decode, register file, execute and the D/X stage.
interface dx_stage_if;
  logic [31:0] instruction_fd;
  logic [31:0] pc_fd;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] instruction_xm;
  logic        branch_taken;
  logic [31:0] instruction_dx;
  logic [31:0] pc_dx;
  logic [31:0] val1_dx;
  logic [31:0] val2_dx;
  logic        mx_rd_rs, wx_rd_rs, mx_rd_rt, wx_rd_rt, mx_rd_rd, wx_rd_rd;
  logic        stall_fd;
  logic [15:0] stall_count;

  modport master (
    output instruction_fd, pc_fd, rs_val, rt_val, instruction_xm, branch_taken,
    input  instruction_dx, pc_dx, val1_dx, val2_dx,
           mx_rd_rs, wx_rd_rs, mx_rd_rt, wx_rd_rt, mx_rd_rd, wx_rd_rd,
           stall_fd, stall_count
  );

  modport slave (
    input  instruction_fd, pc_fd, rs_val, rt_val, instruction_xm, branch_taken,
    output instruction_dx, pc_dx, val1_dx, val2_dx,
           mx_rd_rs, wx_rd_rs, mx_rd_rt, wx_rd_rt, mx_rd_rd, wx_rd_rd,
           stall_fd, stall_count
  );
endinterface

// File: rtl/dx_stage_hazard_cmp.sv
// Per-source RAW match of a consumer instruction against one producer.
module hazard_cmp
  import dx_pkg::*;
(
  input  logic [31:0] prod_instr,
  input  logic [31:0] cons_instr,
  output src_match_t  match
);
  logic       wr;
  logic [4:0] dst;

  assign wr  = writes_rd(prod_instr);
  assign dst = f_rd(prod_instr);

  // wr already excludes r0, so no separate zero check is needed here.
  always_comb begin
    match    = '0;
    match.rs = wr && uses_rs(cons_instr) && (f_rs(cons_instr) == dst);
    match.rt = wr && uses_rt(cons_instr) && (f_rt(cons_instr) == dst);
    match.rd = wr && uses_rd(cons_instr) && (f_rd(cons_instr) == dst);
  end
endmodule

// File: rtl/dx_stage.sv
// D/X pipeline latch with load-use stall, branch squash and registered bypass
// selects. Define DX_BYPASS_EN for forwarding; otherwise full interlock.
module dx_stage
  import dx_pkg::*;
(
  input logic       clk,
  input logic       reset,
  dx_stage_if.slave bus
);
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] val1_q, val1_d;
  logic [31:0] val2_q, val2_d;
  logic [15:0] cnt_q, cnt_d;
  byp_sel_t    sel_q, sel_d, sel_nxt;
  src_match_t  m_dx, m_xm;
  logic        stall;

  hazard_cmp u_cmp_dx (.prod_instr(instr_q),            .cons_instr(bus.instruction_fd), .match(m_dx));
  hazard_cmp u_cmp_xm (.prod_instr(bus.instruction_xm), .cons_instr(bus.instruction_fd), .match(m_xm));

`ifdef DX_BYPASS_EN
  // Only a load in D/X cannot be forwarded in time; everything else bypasses.
  assign stall = (f_op(instr_q) == OP_LW) && (m_dx != '0);

  always_comb begin
    sel_nxt       = '0;
    sel_nxt.mx_rs = m_dx.rs;
    sel_nxt.wx_rs = m_xm.rs & ~m_dx.rs;
    sel_nxt.mx_rt = m_dx.rt;
    sel_nxt.wx_rt = m_xm.rt & ~m_dx.rt;
    sel_nxt.mx_rd = m_dx.rd;
    sel_nxt.wx_rd = m_xm.rd & ~m_dx.rd;
  end
`else
  assign stall   = (m_dx != '0) || (m_xm != '0);
  assign sel_nxt = '0;
`endif

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    val1_d  = val1_q;
    val2_d  = val2_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    if (bus.branch_taken) begin
      instr_d = NOP;
      pc_d    = '0;
      val1_d  = '0;
      val2_d  = '0;
      sel_d   = '0;
    end else if (stall) begin
      instr_d = NOP;
      pc_d    = '0;
      val1_d  = '0;
      val2_d  = '0;
      sel_d   = '0;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else begin
      instr_d = bus.instruction_fd;
      pc_d    = bus.pc_fd;
      val1_d  = bus.rs_val;
      val2_d  = bus.rt_val;
      sel_d   = sel_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP;
      pc_q    <= '0;
      val1_q  <= '0;
      val2_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      val1_q  <= val1_d;
      val2_q  <= val2_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.instruction_dx = instr_q;
  assign bus.pc_dx          = pc_q;
  assign bus.val1_dx        = val1_q;
  assign bus.val2_dx        = val2_q;
  assign bus.mx_rd_rs       = sel_q.mx_rs;
  assign bus.wx_rd_rs       = sel_q.wx_rs;
  assign bus.mx_rd_rt       = sel_q.mx_rt;
  assign bus.wx_rd_rt       = sel_q.wx_rt;
  assign bus.mx_rd_rd       = sel_q.mx_rd;
  assign bus.wx_rd_rd       = sel_q.wx_rd;
  assign bus.stall_fd       = stall;
  assign bus.stall_count    = cnt_q;
endmodule

// File: tb/tb_dx_stage.sv
// Directed + random bench for dx_stage; expected latch contents are queued
// when each fd instruction is driven and checked after the next clock edge.
module tb_dx_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  dx_stage_if bus ();

  dx_stage dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [5:0]  sel;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] m_dx = 32'h0, m_xm = 32'h0, pc_ctr = 32'h100;
  logic [15:0] m_cnt = 16'h0;

`ifdef DX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [4:0] R = 5'b00000, ADDI = 5'b00101, LW = 5'b01000;
  localparam logic [4:0] SW = 5'b00111, BNE = 5'b00010, BLT = 5'b00110;

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [16:0] lo);
    return {op, rd, rs, lo};
  endfunction

  function automatic logic [31:0] rr(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {R, rd, rs, rt, 12'h0};
  endfunction

  // Register set written by an instruction (r0 never appears).
  function automatic logic [31:0] dmask(input logic [31:0] i);
    logic [31:0] m = '0;
    if ((i[31:27] == R || i[31:27] == ADDI || i[31:27] == LW) && i[26:22] != 5'd0)
      m[i[26:22]] = 1'b1;
    return m;
  endfunction

  // Register set read by an instruction, r0 excluded.
  function automatic logic [31:0] smask(input logic [31:0] c);
    logic [31:0] m = '0;
    logic [4:0] op = c[31:27];
    if (op inside {R, ADDI, LW, SW, BNE, BLT}) m[c[21:17]] = 1'b1;
    if (op == R) m[c[16:12]] = 1'b1;
    if (op inside {SW, BNE, BLT}) m[c[26:22]] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic logic [5:0] byp(input logic [31:0] c, input logic [31:0] dd, input logic [31:0] dx);
    logic [5:0] s = '0;
    logic [4:0] op = c[31:27];
    if (op inside {R, ADDI, LW, SW, BNE, BLT}) begin
      s[5] = dd[c[21:17]];
      s[4] = dx[c[21:17]] & ~s[5];
    end
    if (op == R) begin
      s[3] = dd[c[16:12]];
      s[2] = dx[c[16:12]] & ~s[3];
    end
    if (op inside {SW, BNE, BLT}) begin
      s[1] = dd[c[26:22]];
      s[0] = dx[c[26:22]] & ~s[1];
    end
    return BYP ? s : 6'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [5:0] dut_sel();
    return {bus.mx_rd_rs, bus.wx_rd_rs, bus.mx_rd_rt, bus.wx_rd_rt, bus.mx_rd_rd, bus.wx_rd_rd};
  endfunction

  // One clock: drive fd, check combinational stall, then check the latch.
  task automatic cycle(input logic [31:0] ins, input logic br, output bit st, output bit st_obs);
    exp_t e;
    logic [31:0] v1, v2, sm, dd, dx;
    v1 = $urandom;
    v2 = $urandom;
    bus.instruction_fd = ins;
    bus.pc_fd          = pc_ctr;
    bus.rs_val         = v1;
    bus.rt_val         = v2;
    bus.instruction_xm = m_xm;
    bus.branch_taken   = br;
    #1;
    sm = smask(ins);
    dd = dmask(m_dx);
    dx = dmask(m_xm);
    if (BYP) st = (m_dx[31:27] == LW) && ((dd & sm) != 0);
    else     st = ((dd | dx) & sm) != 0;
    st_obs = bus.stall_fd;
    chk("stall_fd", 32'(bus.stall_fd), 32'(st));
    e = '{instr: 32'h0, pc: 32'h0, v1: 32'h0, v2: 32'h0, sel: 6'h0, cnt: m_cnt};
    if (!br && st) e.cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
    else if (!br) begin
      e.instr = ins; e.pc = pc_ctr; e.v1 = v1; e.v2 = v2;
      e.sel = byp(ins, dd, dx);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("instruction_dx", bus.instruction_dx, e.instr);
    chk("pc_dx", bus.pc_dx, e.pc);
    chk("val1_dx", bus.val1_dx, e.v1);
    chk("val2_dx", bus.val2_dx, e.v2);
    chk("bypass_sel", 32'(dut_sel()), 32'(e.sel));
    chk("stall_count", 32'(bus.stall_count), 32'(e.cnt));
    m_xm  = m_dx;
    m_dx  = e.instr;
    m_cnt = e.cnt;
    if (!br && !st) pc_ctr = pc_ctr + 32'd1;
  endtask

  // Issue one instruction, repeating it while stalled; returns DUT-seen bubbles.
  task automatic issue(input logic [31:0] ins, input logic br, output int bub);
    bit st, so;
    bub = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(ins, br, st, so);
      bub += int'(so);
      if (!st || br) return;
    end
    n_assert++;
    n_fail++;
    $error("FAIL issue_bound observed=stalled expected=issued within 4 cycles");
  endtask

  initial begin
    int b;
    logic [4:0] ops [6];
    ops = '{R, ADDI, LW, SW, BNE, BLT};
    bus.instruction_fd = '0; bus.pc_fd = '0; bus.rs_val = '0; bus.rt_val = '0;
    bus.instruction_xm = '0; bus.branch_taken = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("reset_instruction_dx", bus.instruction_dx, 32'h0);
    chk("reset_stall_count", 32'(bus.stall_count), 32'h0);
    chk("reset_sel", 32'(dut_sel()), 32'h0);
    chk("reset_stall_fd", 32'(bus.stall_fd), 32'h0);
    @(posedge clk);
    #3 reset = 1'b0;

    // Bypass from M.
    issue(rr(3, 1, 2), 1'b0, b);
    issue(rr(4, 3, 5), 1'b0, b);
    chk("mx_bubbles", b, BYP ? 0 : 2);
    if (BYP) chk("mx_rd_rs", 32'(bus.mx_rd_rs), 32'h1);

    // Load-use.
    issue(enc(LW, 5, 1, 0), 1'b0, b);
    issue(enc(ADDI, 6, 5, 4), 1'b0, b);
    chk("loaduse_bubbles", b, BYP ? 1 : 2);
    if (BYP) chk("loaduse_wx_rd_rs", 32'(bus.wx_rd_rs), 32'h1);

    // Register zero.
    issue(rr(0, 1, 2), 1'b0, b);
    issue(rr(4, 0, 0), 1'b0, b);
    chk("r0_bubbles", b, 0);
    chk("r0_sel", 32'(dut_sel()), 32'h0);

    // MX over WX priority.
    issue(rr(7, 1, 1), 1'b0, b);
    issue(rr(7, 2, 2), 1'b0, b);
    issue(rr(8, 7, 0), 1'b0, b);
    chk("prio_bubbles", b, BYP ? 0 : 2);
    chk("prio_sel", 32'(dut_sel()), BYP ? 32'h20 : 32'h0);

    // lw -> lw dependency, then lw with an independent follower.
    issue(enc(LW, 9, 1, 0), 1'b0, b);
    issue(enc(LW, 10, 9, 0), 1'b0, b);
    chk("lwlw_bubbles", b, BYP ? 1 : 2);
    issue(enc(LW, 11, 1, 0), 1'b0, b);
    issue(rr(12, 1, 2), 1'b0, b);
    chk("lw_indep_bubbles", b, 0);

    // Store data through the rd path.
    issue(rr(13, 1, 2), 1'b0, b);
    issue(enc(SW, 13, 14, 0), 1'b0, b);
    if (BYP) chk("sw_mx_rd_rd", 32'(bus.mx_rd_rd), 32'h1);

    // Branch flush coincident with a load-use stall.
    issue(enc(LW, 5, 1, 0), 1'b0, b);
    issue(enc(ADDI, 6, 5, 4), 1'b1, b);
    chk("flush_saw_stall", b, 1);
    chk("flush_nop", bus.instruction_dx, 32'h0);

    // Random mix over a small register window.
    for (int i = 0; i < 40; i++)
      issue(enc(ops[$urandom_range(0, 5)], 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), {5'($urandom_range(0, 7)), 12'h0}), 1'b0, b);

    // Asynchronous reset in the middle of a stall.
    issue(enc(LW, 5, 1, 0), 1'b0, b);
    bus.instruction_fd = enc(ADDI, 6, 5, 4);
    bus.instruction_xm = m_xm;
    bus.branch_taken   = 1'b0;
    #1;
    chk("pre_reset_stall", 32'(bus.stall_fd), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("midreset_instruction_dx", bus.instruction_dx, 32'h0);
    chk("midreset_stall_count", 32'(bus.stall_count), 32'h0);
    chk("midreset_stall_fd", 32'(bus.stall_fd), 32'h0);
    chk("midreset_sel", 32'(dut_sel()), 32'h0);
    #2 reset = 1'b0;
    m_dx = 32'h0; m_xm = 32'h0; m_cnt = 16'h0;
    sb.delete();
    issue(rr(20, 1, 2), 1'b0, b);
    chk("post_reset_bubbles", b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dx_stage.md
# dx_stage

Decode/execute pipeline stage for the 5-stage 32-bit processor. It registers the decoded instruction, PC and register-file operands into the D/X latch and produces registered bypass selects for the execute stage. It detects load-use hazards and stalls fetch/decode for one bubble cycle, and squashes the latch on a taken branch. It sits between the register file read and the execute stage, and consumes that stage's `branch` output.

## Interface
Parameters:
- none; widths fixed at 32-bit data and 5-bit register specifiers.

Ports (`name  direction  width  meaning`):
- `clk  in  1  pipeline clock, rising edge`
- `reset  in  1  asynchronous, active-high; clears all state`
- `instruction_fd  in  32  instruction leaving fetch/decode`
- `pc_fd  in  32  PC+1 of `instruction_fd``
- `rs_val  in  32  register-file read of rs`
- `rt_val  in  32  register-file read of rt, or of rd for sw/bne/blt`
- `instruction_xm  in  32  instruction currently in X/M latch`
- `branch_taken  in  1  execute-stage branch decision this cycle`
- `instruction_dx  out  32  latched instruction to execute`
- `pc_dx  out  32  latched PC`
- `val1_dx, val2_dx  out  32 each  latched operands`
- `mx_rd_rs, wx_rd_rs, mx_rd_rt, wx_rd_rt, mx_rd_rd, wx_rd_rd  out  1 each  registered bypass selects`
- `stall_fd  out  1  combinational; hold PC and F/D latch this cycle`
- `stall_count  out  16  saturating count of bubble cycles inserted`

## Operation
Field and opcode definitions:
- Fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12].
- Opcodes: R-type 00000, addi 00101, lw 01000, sw 00111, bne 00010, blt 00110.

Writers and sources:
- Writers: R-type, addi, lw, each writing rd. A writer with rd = 0 counts as a non-writer.
- Sources by type:
  - R-type: rs, rt.
  - addi, lw: rs.
  - sw, bne, blt: rs and rd. The rd path uses the `_rd` selects.

Load-use hazard:
- `stall_fd` = 1 when the current D/X instruction is lw, its rd ≠ 0, and its rd matches any source of `instruction_fd`.

Each rising edge, in priority order:
1. `branch_taken`: load NOP (32'h0), clear all selects. No stall is counted.
2. `stall_fd`: load NOP, clear selects, increment `stall_count`. It saturates at 16'hFFFF.
3. Otherwise: latch the fd inputs and compute the selects.

Bypass selects, computed for incoming source register s:
- `mx_*` = 1 when the current D/X instruction (next cycle's M) writes s, and s ≠ 0.
- `wx_*` = 1 when `instruction_xm` (next cycle's W) writes s, s ≠ 0, and `mx_*` = 0. MX has priority.
- `_rt` selects are used for R-type sources; `_rd` selects for sw/bne/blt.

Register-file assumption: same-cycle write/read is resolved inside the register file, so no W-to-D bypass exists here.

## Timing
- Reset: every output = 0; `instruction_dx` = NOP; `stall_count` = 0. `stall_fd` evaluates to 0 once the latch holds NOP.
- Latency: one cycle from fd inputs to dx outputs.
- Load-use: exactly one bubble cycle per hazard. On the following cycle the consumer enters with `wx_*` = 1.
- Branch asserted in the same cycle as a stall: the flush wins, and `stall_count` is unchanged.
- Reset asserted mid-stall: the stall is abandoned immediately (asynchronous).
- Back-to-back lw→lw dependency: one bubble.
- lw followed by an independent instruction: no bubble.

## Configuration
`DX_BYPASS_EN`:
- Defined: behaviour as above.
- Undefined:
  - All six select outputs are tied to 0.
  - `stall_fd` asserts on any RAW dependency of `instruction_fd` on a writer in D/X or in `instruction_xm`. This is full interlock, up to two bubbles.
  - `stall_count` counts every bubble.

## Structure
- Package `dx_pkg` holds:
  - opcode localparams
  - field-slice functions
  - `NOP` constant
  - `writes_rd(instr)` function
  - `uses_rs/uses_rt/uses_rd(instr)` functions
- Sub-module `hazard_cmp` is combinational. It takes producer and consumer instructions and outputs per-source match bits (rs, rt, rd). It is instantiated twice, for D/X and for X/M producers.

## Test plan
- Bypass from M: add r3,r1,r2 then add r4,r3,r5, no stall → second instruction latched with `mx_rd_rs`=1, `wx_rd_rs`=0, `stall_fd`=0.
- Load-use: lw r5,0(r1) then addi r6,r5,4 → `stall_fd`=1 for one cycle, NOP in D/X, then addi latched with `wx_rd_rs`=1, `stall_count`=1.
- Register zero: add r0,r1,r2 then add r4,r0,r0 → all selects 0.
- Branch flush: `branch_taken`=1 coincident with a load-use stall → D/X = NOP, selects 0, `stall_count` unchanged.
- Priority: r7 written by both D/X and `instruction_xm`, consumer reads r7 → `mx_rd_rs`=1, `wx_rd_rs`=0. With `DX_BYPASS_EN` undefined → selects 0, two bubbles.
- Reset: assert reset asynchronously mid-stall → all outputs 0 immediately, `stall_count` = 0.
